// File: rtl/dmem_pkg.sv
// Shared widths and FSM encoding for the data_mem arbiter.
package dmem_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input request picker: one-hot grant from req, round-robin pointer or fixed priority.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On conflict the pointer names the preferred port unless port 0 is pinned.
            2'b11:   gnt = (fixed_prio || !rr) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises two req/ack requesters onto the single-port data_mem (IDLE -> ACCESS -> DONE).
// Handshake: a port holds req with we/addr/wdata stable until it sees its one-cycle ack; a req still high in IDLE is a new access.
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_in,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_out,
    output logic [1:0]    dbg_state
);
    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rr_q, rr_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [1:0]    arb_gnt;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .rr         (rr_q),
        .fixed_prio (FIXED_PRIO),
        .gnt        (arb_gnt)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rr_d     = rr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0     = 1'b0;
        ack1     = 1'b0;
        busy     = 1'b0;
        mem_add  = '0;
        mem_in   = '0;
        mem_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt[1];
                    we_d    = arb_gnt[1] ? we1 : we0;
                    addr_d  = arb_gnt[1] ? addr1 : addr0;
                    wdata_d = arb_gnt[1] ? wdata1 : wdata0;
                    rr_d    = ~arb_gnt[1];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy    = 1'b1;
                mem_add = addr_q;
                mem_in  = wdata_q;
                mem_wr  = we_q;
                if (!we_q) begin
                    if (gnt_q) rdata1_d = mem_out;
                    else       rdata0_d = mem_out;
                end
                state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                mem_add = addr_q;
                mem_in  = wdata_q;
                ack0    = ~gnt_q;
                ack1    = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rr_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rr_q     <= rr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural data_mem (combinational read, clocked write).
module tb_data_mem_arbiter;
    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, mem_wr;
    logic [7:0] rdata0, rdata1, mem_add, mem_in, mem_out;
    logic [1:0] dbg_state;
    // fixed-priority instance outputs
    logic       ack0_f, ack1_f, busy_f, mem_wr_f;
    logic [7:0] rdata0_f, rdata1_f, mem_add_f, mem_in_f, mem_out_f;
    logic [1:0] dbg_state_f;

    logic [7:0] mem [0:255];
    logic [7:0] exp_mem [0:255];
    logic [7:0] exp_q[$];
    int         gnt_log[$];
    bit         log_en;
    int         total, bad, wr_cnt, wr_bad;

    data_mem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_add(mem_add), .mem_in(mem_in), .mem_wr(mem_wr), .mem_out(mem_out),
        .dbg_state(dbg_state)
    );

    data_mem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1'b1)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0_f), .ack1(ack1_f), .rdata0(rdata0_f), .rdata1(rdata1_f), .busy(busy_f),
        .mem_add(mem_add_f), .mem_in(mem_in_f), .mem_wr(mem_wr_f), .mem_out(mem_out_f),
        .dbg_state(dbg_state_f)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_out   = mem[mem_add];
    assign mem_out_f = mem[mem_add_f];
    always @(posedge clk) if (mem_wr) mem[mem_add] <= mem_in;

    always @(negedge clk) begin
        if (mem_wr) wr_cnt++;
        if (rst_n && mem_wr && dbg_state != 2'd1) wr_bad++;
        if (log_en && ack0) gnt_log.push_back(0);
        if (log_en && ack1) gnt_log.push_back(1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // driver: present a request, wait for its ack (bounded), drop req on the edge that samples ack
    task automatic drive_req(input int port, input bit we, input logic [7:0] a, input logic [7:0] wd,
                             output int lat, output logic [7:0] rd);
        bit got;
        got = 0;
        lat = 0;
        rd  = '0;
        if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
        else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if ((port == 0) ? ack0 : ack1) begin
                got = 1;
                rd  = (port == 0) ? rdata0 : rdata1;
                if (we) exp_mem[a] = wd;
            end
        end
        if (!got) lat = -1;
        @(posedge clk);
        #1;
        if (port == 0) req0 = 0;
        else           req1 = 0;
    endtask

    task automatic apply_reset();
        req0 = 0; req1 = 0;
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 8'hff; addr1 = 8'h7f; wdata0 = 8'haa; wdata1 = 8'h55;
        #1;
        total++; if (ack0 !== 1'b0)      begin bad++; $display("FAIL reset_ack0 got=%b want=0", ack0); end
        total++; if (ack1 !== 1'b0)      begin bad++; $display("FAIL reset_ack1 got=%b want=0", ack1); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mem_wr !== 1'b0)    begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        total++; if (mem_add !== 8'h00)  begin bad++; $display("FAIL reset_mem_add got=%h want=00", mem_add); end
        total++; if (mem_in !== 8'h00)   begin bad++; $display("FAIL reset_mem_in got=%h want=00", mem_in); end
        total++; if (rdata0 !== 8'h00)   begin bad++; $display("FAIL reset_rdata0 got=%h want=00", rdata0); end
        total++; if (rdata1 !== 8'h00)   begin bad++; $display("FAIL reset_rdata1 got=%h want=00", rdata1); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy, mem_wr, ack0} !== 3'b000) begin bad++; $display("FAIL reset_held got=%b want=000", {busy, mem_wr, ack0}); end
        req0 = 0; req1 = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int lat, w0;
        logic [7:0] rd, e;
        w0 = wr_cnt;
        drive_req(0, 1, 8'd3, 8'd11, lat, rd);
        total++; if (lat !== 3)        begin bad++; $display("FAIL wr_latency got=%0d want=3", lat); end
        total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL wr_pulse_count got=%0d want=1", wr_cnt - w0); end
        w0 = wr_cnt;
        exp_q.push_back(8'd11);
        drive_req(0, 0, 8'd3, 8'd0, lat, rd);
        e = exp_q.pop_front();
        total++; if (lat !== 3)        begin bad++; $display("FAIL rd_latency got=%0d want=3", lat); end
        total++; if (rd !== e)         begin bad++; $display("FAIL rd_data got=%h want=%h", rd, e); end
        total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL rd_no_wr got=%0d want=0", wr_cnt - w0); end
        total++; if (rdata0 !== e)     begin bad++; $display("FAIL rdata0_held got=%h want=%h", rdata0, e); end
    endtask

    task automatic test_conflict();
        int lat0, lat1;
        logic [7:0] rd0, rd1, e;
        apply_reset();
        fork
            drive_req(0, 1, 8'd5, 8'd8, lat0, rd0);
            drive_req(1, 1, 8'd6, 8'd9, lat1, rd1);
        join
        total++; if (lat0 !== 3) begin bad++; $display("FAIL conflict_p0_lat got=%0d want=3", lat0); end
        total++; if (lat1 !== 6) begin bad++; $display("FAIL conflict_p1_lat got=%0d want=6", lat1); end
        exp_q.push_back(8'd8);
        drive_req(0, 0, 8'd5, 8'd0, lat0, rd0);
        e = exp_q.pop_front();
        total++; if (rd0 !== e) begin bad++; $display("FAIL conflict_rd5 got=%h want=%h", rd0, e); end
        exp_q.push_back(8'd9);
        drive_req(1, 0, 8'd6, 8'd0, lat1, rd1);
        e = exp_q.pop_front();
        total++; if (rd1 !== e) begin bad++; $display("FAIL conflict_rd6 got=%h want=%h", rd1, e); end
    endtask

    task automatic test_round_robin();
        int n0, n1;
        apply_reset();
        gnt_log.delete();
        log_en = 1;
        fork
            begin
                int lat; logic [7:0] rd;
                for (int i = 0; i < 4; i++) drive_req(0, 0, 8'd5, 8'd0, lat, rd);
            end
            begin
                int lat; logic [7:0] rd;
                for (int i = 0; i < 4; i++) drive_req(1, 0, 8'd6, 8'd0, lat, rd);
            end
        join
        log_en = 0;
        total++; if (gnt_log.size() !== 8) begin bad++; $display("FAIL rr_count got=%0d want=8", gnt_log.size()); end
        for (int i = 0; i < gnt_log.size() && i < 8; i++) begin
            total++;
            if (gnt_log[i] !== i % 2) begin bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, gnt_log[i], i % 2); end
        end
        // fixed-priority instance: both held high for 12 cycles, port 0 every time
        apply_reset();
        n0 = 0; n1 = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'd5; addr1 = 8'd6;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack0_f) n0++;
            if (ack1_f) n1++;
        end
        req0 = 0; req1 = 0;
        total++; if (n0 !== 4) begin bad++; $display("FAIL fixed_p0_acks got=%0d want=4", n0); end
        total++; if (n1 !== 0) begin bad++; $display("FAIL fixed_p1_acks got=%0d want=0", n1); end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] rd, e, a;
        for (int i = 0; i < 8; i++) begin
            a = 8'(i);
            drive_req(1, 1, a, a + 8'd8, lat, rd);
        end
        for (int i = 0; i < 8; i++) begin
            a = 8'(i);
            exp_q.push_back(a + 8'd8);
            drive_req(0, 0, a, 8'($urandom_range(0, 255)), lat, rd);
            e = exp_q.pop_front();
            total++; if (rd !== e) begin bad++; $display("FAIL b2b_rd addr=%0d got=%h want=%h", i, rd, e); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, n_ack;
        logic [7:0] rd, e;
        req0 = 1; we0 = 1; addr0 = 8'd20; wdata0 = 8'h55;
        @(posedge clk);
        #2;
        total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL mid_pre_wr got=%b want=1", mem_wr); end
        rst_n = 0;
        #1;
        total++; if (mem_wr !== 1'b0)    begin bad++; $display("FAIL mid_mem_wr got=%b want=0", mem_wr); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL mid_state got=%0d want=0", dbg_state); end
        total++; if (rdata0 !== 8'h00)   begin bad++; $display("FAIL mid_rdata0 got=%h want=00", rdata0); end
        req0 = 0;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack0) n_ack++;
        end
        rst_n = 1;
        @(posedge clk);
        #1;
        total++; if (n_ack !== 0) begin bad++; $display("FAIL mid_no_ack got=%0d want=0", n_ack); end
        drive_req(0, 1, 8'd20, 8'h55, lat, rd);
        total++; if (lat !== 3) begin bad++; $display("FAIL mid_reissue_lat got=%0d want=3", lat); end
        exp_q.push_back(8'h55);
        drive_req(0, 0, 8'd20, 8'h00, lat, rd);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL mid_reissue_rd got=%h want=%h", rd, e); end
    endtask

    task automatic test_latched_inputs();
        int lat;
        bit seen;
        logic [7:0] rd, e;
        drive_req(0, 1, 8'd31, 8'h42, lat, rd);
        seen = 0;
        fork
            drive_req(0, 1, 8'd30, 8'h77, lat, rd);
            begin
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clk);
                    if (dbg_state == 2'd1) seen = 1;
                end
                addr0 = 8'd31;
                wdata0 = 8'h99;
            end
        join
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL latch_saw_access got=%b want=1", seen); end
        exp_q.push_back(exp_mem[30]);
        drive_req(0, 0, 8'd30, 8'h00, lat, rd);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL latch_rd30 got=%h want=%h", rd, e); end
        exp_q.push_back(exp_mem[31]);
        drive_req(0, 0, 8'd31, 8'h00, lat, rd);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL latch_rd31 got=%h want=%h", rd, e); end
    endtask

    task automatic test_wr_discipline();
        total++; if (wr_bad !== 0)       begin bad++; $display("FAIL wr_outside_access got=%0d want=0", wr_bad); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        total = 0; bad = 0; wr_cnt = 0; wr_bad = 0; log_en = 0;
        test_reset();
        test_write_read();
        test_conflict();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_latched_inputs();
        test_wr_discipline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
